// File: rtl/uop_issue_arbiter.sv
// uop_issue_arbiter
//   Chooses which uop stream feeds the execute stage each cycle: the main
//   (decoder) stream or the scheduler (interrupt/sequencer) stream.
//   The choice is combinational, so a granted uop issues in the same cycle
//   and executes in the next one.
//   - A sequence that is not finished (last=0) locks the arbiter to its
//     source until that source sends a uop with last=1.
//   - In IDLE the scheduler has priority. After 7 completed scheduler
//     sequences issued while main was waiting, main is given one turn.
//   - While the uop in execute waits on memory (stop), every output is
//     frozen on the execute mirror and no source is accepted.
//
// Ports
//   clk                    clock; all state updates on its rising edge
//   a_rst                  synchronous reset, active low
//   main_valid/uop/temp/last, main_ready     decoder stream handshake
//   sched_valid/uop/temp/last, sched_ready   scheduler stream handshake
//   mem_busy               memory has not finished the uop now in execute
//   uop_next               uop presented to execute (NOP when idle)
//   temp_a / temp_b        main / scheduler temporary for execute
//   next_main / next_sched source tag of uop_next
//   stop                   execute-stage stall
module uop_issue_arbiter #(
  parameter logic [19:0] NOP = 20'b0000_0000_1111_00_000_000
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        main_valid,
  input  logic [19:0] main_uop,
  input  logic [15:0] main_temp,
  input  logic        main_last,
  output logic        main_ready,
  input  logic        sched_valid,
  input  logic [19:0] sched_uop,
  input  logic [15:0] sched_temp,
  input  logic        sched_last,
  output logic        sched_ready,
  input  logic        mem_busy,
  output logic [19:0] uop_next,
  output logic [15:0] temp_a,
  output logic [15:0] temp_b,
  output logic        next_sched,
  output logic        next_main,
  output logic        stop
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MAIN_LOCK  = 2'd1,
    SCHED_LOCK = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  fair_cnt_q, fair_cnt_d;
  logic [19:0] ex_uop_q, ex_uop_d;
  logic [1:0]  ex_src_q, ex_src_d;       // {main, sched}
  logic [15:0] ex_temp_a_q, ex_temp_a_d;
  logic [15:0] ex_temp_b_q, ex_temp_b_d;

  logic grant_sched, grant_main;
  logic xfer_sched, xfer_main;
  logic stall;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    sat_inc3 = (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

  // Stage 0: grant, handshake and issue mux (combinational)
  always_comb begin
    stall       = (ex_uop_q[13] | ex_uop_q[14]) & mem_busy;
    grant_sched = 1'b0;
    grant_main  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // fair_cnt==7 hands one turn to a waiting main stream
        if (sched_valid && (fair_cnt_q != 3'd7 || !main_valid)) grant_sched = 1'b1;
        else if (main_valid)                                     grant_main  = 1'b1;
      end
      SCHED_LOCK: grant_sched = 1'b1;
      MAIN_LOCK:  grant_main  = 1'b1;
      default: ;
    endcase

    sched_ready = grant_sched & ~stall;
    main_ready  = grant_main  & ~stall;
    xfer_sched  = sched_valid & sched_ready;
    xfer_main   = main_valid  & main_ready;
    stop        = stall;

    uop_next   = NOP;
    temp_a     = ex_temp_a_q;
    temp_b     = ex_temp_b_q;
    next_main  = 1'b0;
    next_sched = 1'b0;
    if (stall) begin
      uop_next   = ex_uop_q;
      next_main  = ex_src_q[1];
      next_sched = ex_src_q[0];
    end else if (xfer_sched) begin
      uop_next   = sched_uop;
      temp_b     = sched_temp;
      next_sched = 1'b1;
    end else if (xfer_main) begin
      uop_next   = main_uop;
      temp_a     = main_temp;
      next_main  = 1'b1;
    end
  end

  // Stage 0 -> 1: next-state for the lock FSM, fairness counter and execute mirror
  always_comb begin
    state_d     = state_q;
    fair_cnt_d  = fair_cnt_q;
    ex_uop_d    = ex_uop_q;
    ex_src_d    = ex_src_q;
    ex_temp_a_d = ex_temp_a_q;
    ex_temp_b_d = ex_temp_b_q;
    if (!stall) begin
      ex_uop_d    = uop_next;
      ex_src_d    = {next_main, next_sched};
      ex_temp_a_d = temp_a;
      ex_temp_b_d = temp_b;
      if (xfer_sched) begin
        state_d = sched_last ? IDLE : SCHED_LOCK;
        // only completed sequences that made main wait count against fairness
        if (sched_last && main_valid) fair_cnt_d = sat_inc3(fair_cnt_q);
      end else if (xfer_main) begin
        state_d = main_last ? IDLE : MAIN_LOCK;
        if (main_last) fair_cnt_d = 3'd0;
      end
    end
  end

  // Stage 1: registered state (stall hold is handled in the next-state logic)
  always_ff @(posedge clk) begin
    if (!a_rst) begin
      state_q     <= IDLE;
      fair_cnt_q  <= 3'd0;
      ex_uop_q    <= NOP;
      ex_src_q    <= 2'b00;
      ex_temp_a_q <= 16'd0;
      ex_temp_b_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      fair_cnt_q  <= fair_cnt_d;
      ex_uop_q    <= ex_uop_d;
      ex_src_q    <= ex_src_d;
      ex_temp_a_q <= ex_temp_a_d;
      ex_temp_b_q <= ex_temp_b_d;
    end
  end

endmodule

// File: doc/uop_issue_arbiter.md
UOP_ISSUE_ARBITER -- requirements
Module: uop_issue_arbiter

Interface
REQ-001 Parameter: NOP, 20'b0000_0000_1111_00_000_000, bubble uop issued when nothing is granted.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 a_rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-004 main_valid  input  1  main (decoder) uop stream has a uop.
REQ-005 main_uop  input  20  main uop, same field layout as the execute stage.
REQ-006 main_temp  input  16  main immediate/temporary.
REQ-007 main_last  input  1  main uop ends an atomic sequence.
REQ-008 main_ready  output  1  main uop accepted this cycle when high with main_valid.
REQ-009 sched_valid, sched_uop[19:0], sched_temp[15:0], sched_last  input  scheduler (interrupt/sequencer) stream, same meanings as main_*.
REQ-010 sched_ready  output  1  sched uop accepted when high with sched_valid.
REQ-011 mem_busy  input  1  memory has not completed the request of the uop now in execute.
REQ-012 uop_next  output  20  uop presented to execute stage.
REQ-013 temp_a  output  16  main temporary (execute uses it when next_sched=0).
REQ-014 temp_b  output  16  sched temporary (execute uses it when next_sched=1).
REQ-015 next_sched, next_main  output  1 each  source tag of uop_next.
REQ-016 stop  output  1  execute-stage stall.

Function
REQ-017 Internal state: ex_uop[19:0] and ex_src[1:0] (mirror of uop/source now in execute), ex_temp_a/ex_temp_b[15:0], FSM {IDLE, MAIN_LOCK, SCHED_LOCK}, fair_cnt[2:0].
REQ-018 stop SHALL be combinational: (ex_uop[13] | ex_uop[14]) & mem_busy.
REQ-019 While stop=1: main_ready=sched_ready=0; uop_next=ex_uop; temp_a/temp_b=ex_temp_a/ex_temp_b; next_main/next_sched=ex_src; FSM, fair_cnt, ex_* unchanged.
REQ-020 Transfer on a source = valid & ready at a rising edge; ready SHALL only be high for the granted source and only when stop=0.
REQ-021 Grant in IDLE: sched if sched_valid and (fair_cnt!=7 or !main_valid); else main if main_valid; else none.
REQ-022 Grant in SCHED_LOCK: sched only; MAIN_LOCK: main only; lock is held even when the locked source's valid is low.
REQ-023 With a granted source valid: uop_next=its uop, its temp on its temp port, next_main or next_sched=1 accordingly; zero-latency (combinational) issue, executes next cycle.
REQ-024 No transfer and stop=0: uop_next=NOP, next_main=next_sched=0, temp_a/temp_b=ex_temp_a/ex_temp_b.
REQ-025 Each rising edge with stop=0: ex_uop<=uop_next, ex_src<={next_main,next_sched}, ex_temp_a<=temp_a, ex_temp_b<=temp_b.
REQ-026 FSM: transfer with last=0 -> lock of that source; transfer with last=1 -> IDLE; no transfer -> state held.
REQ-027 fair_cnt: +1 (saturating at 7) on a sched transfer with sched_last=1 while main_valid=1; cleared on a main transfer with main_last=1; else held.
REQ-028 Simultaneous sched_valid and main_valid in IDLE with fair_cnt=7: main wins.
REQ-029 Single-uop sequence (last=1 on first uop) SHALL not enter a lock state.

Reset
REQ-030 a_rst=0 at an edge: FSM=IDLE, fair_cnt=0, ex_uop=NOP, ex_src=00, ex_temp_a=ex_temp_b=0; takes priority over stop and any transfer, including mid-sequence.
REQ-031 In the cycle after reset: stop=0, ready outputs follow REQ-021, uop_next=NOP when no valid.

Verification
REQ-032 Reset then no valid for 5 cycles -> uop_next=NOP, next_main=next_sched=0, stop=0, temp_a=temp_b=0.
REQ-033 main 3-uop sequence (last on 3rd), sched_valid=1 from 2nd cycle -> sched_ready=0 until main's 3rd transfer; sched issues in the following cycle.
REQ-034 uop with bit13=1 issued, mem_busy=1 for 3 cycles -> stop=1 for 3 cycles, uop_next equals that uop, both ready=0; next uop issues when mem_busy drops.
REQ-035 sched and main always valid, all last=1 -> 7 sched uops, then 1 main uop, fair_cnt back to 0, pattern repeats.
REQ-036 SCHED_LOCK with sched_valid=0 two cycles, main_valid=1 -> two NOP bubbles, main_ready=0.
REQ-037 a_rst=0 during MAIN_LOCK with stop=1 -> next cycle FSM=IDLE, stop=0, sched_valid=1 granted immediately.
